// File: rtl/timer_mc.sv
// Multi-channel bus-attached timer: prescaled counter (up-wrap, up/down, one-shot),
// CHANNELS compare/PWM channels, W1C status flags and a maskable level interrupt.

module timer_mc_chan #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] count_next,
  input  logic [WIDTH-1:0] cmp,
  output logic             hit,
  output logic             cmp_out
);
  assign hit = tick && (count_next == cmp);

  // PWM output follows the counter state one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cmp_out <= 1'b0;
    else       cmp_out <= (count < cmp);
  end
endmodule

module timer_mc #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h40E0,
  parameter int          WIDTH           = 16,
  parameter int          CHANNELS        = 4,
  parameter int          PRESCALER_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_bus_select,
  input  logic [31:0]         data_bus_addr,
  input  logic [1:0]          data_bus_mode,
  input  logic [31:0]         data_bus_write,
  output logic [31:0]         data_bus_read,
  output logic                timer_irq,
  output logic [CHANNELS-1:0] comparator_out
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [29:0] word_off;
  logic [3:0]  word;
  logic        in_block, bus_wr, bus_rd;
  logic        wr_ctrl, wr_presc, wr_top, wr_count, wr_status, wr_irqen, clr;
  logic        unused_bits;

  logic                             en, updown, oneshot, dir;
  logic [PRESCALER_WIDTH-1:0]       presc, pc;
  logic [WIDTH-1:0]                 top, count, count_next;
  logic [CHANNELS:0]                status, irqen, flag_set, flag_clr;
  logic [CHANNELS-1:0][WIDTH-1:0]   cmp;
  logic [CHANNELS-1:0]              hit;
  logic                             tick, tick_eff, ovf_evt, dir_next;

  assign word_off    = data_bus_addr[31:2] - BASE_ADDRESS[31:2];
  assign in_block    = (word_off[29:4] == '0);
  assign word        = word_off[3:0];
  assign bus_wr      = data_bus_select && (data_bus_mode == 2'b10) && in_block;
  assign bus_rd      = data_bus_select && (data_bus_mode == 2'b01) && in_block;
  assign unused_bits = ^{data_bus_addr[1:0], data_bus_write};

  assign wr_ctrl   = bus_wr && (word == 4'h0);
  assign wr_presc  = bus_wr && (word == 4'h1);
  assign wr_top    = bus_wr && (word == 4'h2);
  assign wr_count  = bus_wr && (word == 4'h3);
  assign wr_status = bus_wr && (word == 4'h4);
  assign wr_irqen  = bus_wr && (word == 4'h5);
  assign clr       = wr_ctrl && data_bus_write[3];

  assign tick = en && (pc == presc);
  // A software COUNT write or CLR replaces the tick's counter update entirely.
  assign tick_eff = tick && !wr_count && !clr;

  always_comb begin
    count_next = count;
    dir_next   = dir;
    ovf_evt    = 1'b0;
    if (tick) begin
      if (!updown) begin
        if (count == top || count == CNT_MAX) begin
          count_next = '0;
          ovf_evt    = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end else if (top == '0) begin
        count_next = '0;
        dir_next   = 1'b0;
        ovf_evt    = 1'b1;
      end else if (!dir) begin
        // Above TOP (after a TOP rewrite) the counter runs to all-ones and wraps.
        if (count == top) begin
          count_next = count - 1'b1;
          dir_next   = 1'b1;
        end else if (count == CNT_MAX) begin
          count_next = '0;
          ovf_evt    = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          count_next = {{(WIDTH-1){1'b0}}, 1'b1};
          dir_next   = 1'b0;
          ovf_evt    = 1'b1;
        end else begin
          count_next = count - 1'b1;
        end
      end
      if (ovf_evt && oneshot) count_next = '0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    timer_mc_chan #(.WIDTH(WIDTH)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick_eff),
      .count      (count),
      .count_next (count_next),
      .cmp        (cmp[i]),
      .hit        (hit[i]),
      .cmp_out    (comparator_out[i])
    );
  end

  assign flag_set = {hit, tick_eff && ovf_evt};
  assign flag_clr = wr_status ? data_bus_write[CHANNELS:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      updown  <= 1'b0;
      oneshot <= 1'b0;
      dir     <= 1'b0;
      presc   <= '0;
      pc      <= '0;
      top     <= '0;
      count   <= '0;
      status  <= '0;
      irqen   <= '0;
      cmp     <= '0;
    end else begin
      if (clr)     pc <= '0;
      else if (en) pc <= tick ? '0 : pc + 1'b1;

      if (wr_count) begin
        count <= data_bus_write[WIDTH-1:0];
      end else if (clr) begin
        count <= '0;
        dir   <= 1'b0;
      end else if (tick) begin
        count <= count_next;
        dir   <= dir_next;
      end

      if (wr_ctrl) begin
        en      <= data_bus_write[0];
        updown  <= data_bus_write[1];
        oneshot <= data_bus_write[2];
      end else if (tick_eff && ovf_evt && oneshot) begin
        en <= 1'b0;
      end

      // Hardware set wins over a same-cycle write-1-to-clear.
      status <= (status & ~flag_clr) | flag_set;

      if (wr_presc) presc <= data_bus_write[PRESCALER_WIDTH-1:0];
      if (wr_top)   top   <= data_bus_write[WIDTH-1:0];
      if (wr_irqen) irqen <= data_bus_write[CHANNELS:0];
      for (int i = 0; i < CHANNELS; i++)
        if (bus_wr && word == 4'(8 + i)) cmp[i] <= data_bus_write[WIDTH-1:0];
    end
  end

  assign timer_irq = |(status & irqen);

  always_comb begin
    data_bus_read = '0;
    if (bus_rd) begin
      case (word)
        4'h0: data_bus_read = {29'd0, oneshot, updown, en};
        4'h1: data_bus_read = 32'(presc);
        4'h2: data_bus_read = 32'(top);
        4'h3: data_bus_read = 32'(count);
        4'h4: data_bus_read = 32'(status);
        4'h5: data_bus_read = 32'(irqen);
        default: begin
          for (int i = 0; i < CHANNELS; i++)
            if (word == 4'(8 + i)) data_bus_read = 32'(cmp[i]);
        end
      endcase
    end
  end
endmodule

// File: doc/timer_mc.md
# timer_mc

Multi-channel, parametrised successor to the single-compare `timer` peripheral on the microcontroller data bus. It provides:

- one counter with a programmable prescaler and TOP value;
- up-wrap, up/down (centre-aligned) and one-shot modes;
- `CHANNELS` independent compare/PWM channels with per-event status flags and a maskable interrupt.

It attaches as a bus slave beside the other peripherals. Its IRQ line feeds one `irq_sources` bit of the core's ICU.

## Interface
- `BASE_ADDRESS`, 32'h40E0: word-aligned base of the register block.
- `WIDTH`, 16: counter, TOP and compare width (8..32).
- `CHANNELS`, 4: number of compare channels (1..8).
- `PRESCALER_WIDTH`, 16: prescaler register width (1..32).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `data_bus_select` in 1: slave select from `bus_arbiter`.
- `data_bus_addr` in 32: byte address.
- `data_bus_mode` in 2: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as idle).
- `data_bus_write` in 32: write data, full word.
- `data_bus_read` out 32: read data, zero-extended.
- `timer_irq` out 1: level interrupt.
- `comparator_out` out CHANNELS: PWM outputs.

## Operation
Register map (offset from `BASE_ADDRESS`, word access only; the low 2 address bits are ignored):
- 0x00 CTRL:
  - bit0 EN;
  - bit1 MODE (0 up-wrap, 1 up/down);
  - bit2 ONESHOT;
  - bit3 CLR, write-only: a 1 zeroes the counter, prescaler and direction; reads 0.
- 0x04 PRESC [PRESCALER_WIDTH-1:0].
- 0x08 TOP [WIDTH-1:0].
- 0x0C COUNT [WIDTH-1:0], read/write.
- 0x10 STATUS: bit0 OVF, bits[CHANNELS:1] CMPF[i]. Write-1-to-clear.
- 0x14 IRQEN: same layout as STATUS.
- 0x20+4*i CMP[i] [WIDTH-1:0], for i < CHANNELS.
- Unmapped offsets inside the block read 0; writes to them are ignored.

Prescaler and tick:
- The prescaler counter `pc` runs while EN=1.
- A tick occurs in a cycle where `pc == PRESC`; `pc` returns to 0 on that cycle, otherwise `pc` increments.
- PRESC=0 therefore gives a tick every cycle.

Counter behaviour on a tick:
- Up-wrap:
  - if COUNT==TOP, COUNT←0 and OVF←1;
  - else COUNT←COUNT+1.
- Up/down:
  - counting up: if COUNT==TOP, direction←down and COUNT←COUNT−1; else COUNT+1;
  - counting down: if COUNT==0, direction←up, COUNT←1 and OVF←1; else COUNT−1;
  - TOP=0 holds COUNT at 0 and sets OVF on every tick.
- ONESHOT=1: the event that sets OVF also clears EN and loads COUNT←0.
- Compare: CMPF[i]←1 on any tick whose new COUNT value equals CMP[i].
- `comparator_out[i]` = (COUNT < CMP[i]), registered from the counter state.
- `timer_irq` = |(STATUS & IRQEN), combinational.

Priorities and boundary cases:
- A bus write to COUNT or CTRL.CLR overrides a same-cycle tick.
- A hardware flag set overrides a same-cycle W1C clear.
- Writing TOP below the current COUNT: COUNT keeps counting up, wrapping at 2^WIDTH−1 to 0 and setting OVF, before it next compares against TOP.
- EN=0 freezes COUNT, `pc` and direction.

Reset values:
- All registers, `pc`, direction (up) and `comparator_out` are 0.
- `timer_irq` is 0 and `data_bus_read` is 0.

## Timing
- A write takes effect on the rising edge of the cycle in which `data_bus_select`=1 and mode=write.
- Reads are combinational: `data_bus_read` is valid in the same cycle as select with mode=read, and is 0 otherwise.
- Tick to COUNT update: the same edge. The flag updates with that edge.
- `comparator_out` lags COUNT by one cycle.
- `timer_irq` is asserted in the cycle after the flag-setting edge, the same cycle the flag becomes visible.
- Asserting `reset` mid-count clears all state immediately, with no dependence on `clk`.

## Test plan
- Up-wrap with PRESC=0, TOP=3, EN=1 → COUNT sequence 0,1,2,3,0. OVF=1 on the 3→0 edge. With IRQEN[0]=1, `timer_irq` rises.
- PRESC=2, TOP=9, CMP0=4 → COUNT advances every 3 cycles. CMPF0 is set on the 3→4 tick. `comparator_out[0]` is high for counts 0–3 and low for 4–9.
- Up/down with TOP=2 → sequence 0,1,2,1,0,1. OVF is set only on the 0→1 turnaround. A ONESHOT=1 variant stops with EN=0 and COUNT=0.
- W1C of OVF in the same cycle as an OVF-setting tick → OVF stays 1. A write of COUNT=7 in the same cycle as a tick → COUNT=7.
- Write TOP=5 while COUNT=8 (WIDTH=8) → counting continues to 255, wraps to 0 with OVF, then wraps at 5.
- Assert `reset` while EN=1 and a flag is set → all outputs and registers are 0 without a clock edge. Reads of offset 0x18 return 0.
